// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Each granted access walks IDLE -> ACCESS -> CAPTURE -> DONE, one state per clock.
module ram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              A_Req,
  input  logic              A_Write,
  input  logic [ADDR_W-1:0] A_Addr,
  input  logic [DATA_W-1:0] A_WData,
  output logic              A_Ack,
  output logic [DATA_W-1:0] A_RData,
  input  logic              B_Req,
  input  logic              B_Write,
  input  logic [ADDR_W-1:0] B_Addr,
  input  logic [DATA_W-1:0] B_WData,
  output logic              B_Ack,
  output logic [DATA_W-1:0] B_RData,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Write,
  output logic [DATA_W-1:0] Mem_Write_Data,
  input  logic [DATA_W-1:0] Mem_Read_Data,
  output logic              Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_lastB;
  logic              r_winB;
  logic              r_write;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWData;
  logic [DATA_W-1:0] r_aRData;
  logic [DATA_W-1:0] r_bRData;
  logic              r_aAck;
  logic              r_bAck;

  logic              w_anyReq;
  logic              w_grantB;

  // On a tie B wins only when A was the most recent grant.
  assign w_anyReq = A_Req | B_Req;
  assign w_grantB = B_Req & (~A_Req | ~r_lastB);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state    <= IDLE;
      r_lastB    <= 1'b1;
      r_winB     <= 1'b0;
      r_write    <= 1'b0;
      r_memAddr  <= '0;
      r_memWData <= '0;
      r_aRData   <= '0;
      r_bRData   <= '0;
      r_aAck     <= 1'b0;
      r_bAck     <= 1'b0;
    end else begin
      r_aAck <= 1'b0;
      r_bAck <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_winB     <= w_grantB;
            r_lastB    <= w_grantB;
            r_write    <= w_grantB ? B_Write : A_Write;
            r_memAddr  <= w_grantB ? B_Addr  : A_Addr;
            r_memWData <= w_grantB ? B_WData : A_WData;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          // RAM data for the ACCESS address is on Mem_Read_Data during this cycle.
          if (!r_write) begin
            if (r_winB) begin
              r_bRData <= Mem_Read_Data;
            end else begin
              r_aRData <= Mem_Read_Data;
            end
          end
          r_aAck  <= ~r_winB;
          r_bAck  <= r_winB;
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Address and data registers load only at a grant, so they hold outside ACCESS.
  assign Mem_Addr       = r_memAddr;
  assign Mem_Write_Data = r_memWData;
  assign Mem_Write      = (r_state == ACCESS) & r_write & Rst_n;
  assign Busy           = (r_state != IDLE);
  assign A_Ack          = r_aAck;
  assign B_Ack          = r_bAck;
  assign A_RData        = r_aRData;
  assign B_RData        = r_bRData;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a behavioural RAM, a scoreboard queue of
// expected acks/read data, and cycle-exact checks of the four-state access.
module tb_ram_arbiter;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              Clk;
  logic              Rst_n;
  logic              A_Req, A_Write, A_Ack;
  logic [ADDR_W-1:0] A_Addr;
  logic [DATA_W-1:0] A_WData, A_RData;
  logic              B_Req, B_Write, B_Ack;
  logic [ADDR_W-1:0] B_Addr;
  logic [DATA_W-1:0] B_WData, B_RData;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Write;
  logic [DATA_W-1:0] Mem_Write_Data;
  logic [DATA_W-1:0] Mem_Read_Data;
  logic              Busy;

  logic [DATA_W-1:0] ramMem [DEPTH];
  logic [DATA_W-1:0] refMem [DEPTH];

  typedef struct {
    logic              isB;
    logic              isRead;
    logic [DATA_W-1:0] data;
    string             tag;
  } expect_t;

  expect_t sbQueue[$];
  expect_t sbItem;
  int      checks = 0;
  int      errors = 0;
  int      writeCount = 0;
  int      writeSnap;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .A_Req(A_Req), .A_Write(A_Write), .A_Addr(A_Addr), .A_WData(A_WData),
    .A_Ack(A_Ack), .A_RData(A_RData),
    .B_Req(B_Req), .B_Write(B_Write), .B_Addr(B_Addr), .B_WData(B_WData),
    .B_Ack(B_Ack), .B_RData(B_RData),
    .Mem_Addr(Mem_Addr), .Mem_Write(Mem_Write), .Mem_Write_Data(Mem_Write_Data),
    .Mem_Read_Data(Mem_Read_Data), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge Clk) begin
    if (Mem_Write) ramMem[Mem_Addr] <= Mem_Write_Data;
    Mem_Read_Data <= ramMem[Mem_Addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Every ack pops the oldest expectation and checks port and read data.
  always @(negedge Clk) begin
    if (Mem_Write) writeCount++;
    if (A_Ack || B_Ack) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedAck", {62'd0, A_Ack, B_Ack}, 64'd0);
      end else begin
        sbItem = sbQueue.pop_front();
        checkOutput({sbItem.tag, "_ackPort"}, {62'd0, A_Ack, B_Ack},
                    sbItem.isB ? 64'd1 : 64'd2);
        if (sbItem.isRead)
          checkOutput({sbItem.tag, "_rdata"}, sbItem.isB ? B_RData : A_RData,
                      {32'd0, sbItem.data});
      end
    end
  end

  function automatic void expectTxn(input logic isB, input logic wr,
                                    input logic [ADDR_W-1:0] addr,
                                    input logic [DATA_W-1:0] data, input string tag);
    expect_t e;
    e.isB    = isB;
    e.isRead = !wr;
    e.data   = wr ? '0 : refMem[addr];
    e.tag    = tag;
    if (wr) refMem[addr] = data;
    sbQueue.push_back(e);
  endfunction

  task automatic applyStimulus(input logic isB, input logic wr,
                               input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input string tag);
    if (isB) begin
      B_Req = 1'b1; B_Write = wr; B_Addr = addr; B_WData = data;
    end else begin
      A_Req = 1'b1; A_Write = wr; A_Addr = addr; A_WData = data;
    end
    expectTxn(isB, wr, addr, data, tag);
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // One isolated transaction with the latency of every state checked.
  task automatic runSingle(input logic isB, input logic wr,
                           input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input string tag);
    applyStimulus(isB, wr, addr, data, tag);
    tick;
    checkOutput({tag, "_accessBusy"}, Busy, 1);
    checkOutput({tag, "_accessAddr"}, Mem_Addr, addr);
    checkOutput({tag, "_accessWrite"}, Mem_Write, wr);
    if (wr) checkOutput({tag, "_accessWData"}, Mem_Write_Data, data);
    tick;
    checkOutput({tag, "_captureNoWriteNoAck"}, {Mem_Write, A_Ack, B_Ack}, 0);
    tick;
    checkOutput({tag, "_doneAck"}, {A_Ack, B_Ack}, isB ? 2'b01 : 2'b10);
    checkOutput({tag, "_doneNoWrite"}, Mem_Write, 0);
    if (isB) B_Req = 1'b0; else A_Req = 1'b0;
    tick;
    checkOutput({tag, "_idle"}, {Busy, A_Ack, B_Ack}, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ramMem[i] = 32'hC0DE0000 | i;
      refMem[i] = 32'hC0DE0000 | i;
    end
    Rst_n = 1'b0;
    A_Req = 0; A_Write = 0; A_Addr = '0; A_WData = '0;
    B_Req = 0; B_Write = 0; B_Addr = '0; B_WData = '0;

    // Reset state
    tick; tick;
    checkOutput("rstBusyAck", {Busy, A_Ack, B_Ack, Mem_Write}, 0);
    checkOutput("rstRData", {A_RData, B_RData}, 0);
    checkOutput("rstMemAddrData", {Mem_Addr, Mem_Write_Data}, 0);
    Rst_n = 1'b1;
    tick;
    checkOutput("postRstIdle", {Busy, A_Ack, B_Ack, Mem_Write}, 0);

    // Single write then read on port A
    writeSnap = writeCount;
    runSingle(1'b0, 1'b1, 6'd5, 32'hDEADBEEF, "wrA5");
    checkOutput("wrA5_onePulse", writeCount - writeSnap, 1);
    runSingle(1'b0, 1'b0, 6'd5, '0, "rdA5");
    checkOutput("rdA5_bUntouched", B_RData, 0);

    // Tie after reset: A first, then strict alternation with 4-cycle spacing
    Rst_n = 1'b0;
    tick; tick;
    Rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'd1, '0, "tieA0");
    applyStimulus(1'b1, 1'b0, 6'd2, '0, "tieB0");
    expectTxn(1'b0, 1'b0, 6'd1, '0, "tieA1");
    expectTxn(1'b1, 1'b0, 6'd2, '0, "tieB1");
    tick;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("tie%0d_addr", i), Mem_Addr, i[0] ? 6'd2 : 6'd1);
      tick; tick;
      checkOutput($sformatf("tie%0d_ack", i), {A_Ack, B_Ack}, i[0] ? 2'b01 : 2'b10);
      if (i == 3) begin
        A_Req = 1'b0;
        B_Req = 1'b0;
      end
      tick;
      checkOutput($sformatf("tie%0d_idle", i), Busy, 0);
      tick;
    end
    checkOutput("tieStopped", Busy, 0);

    // B read at top address; request fields change mid-flight
    applyStimulus(1'b1, 1'b0, 6'd63, '0, "midB63");
    tick;
    checkOutput("midB63_addr", Mem_Addr, 63);
    B_Addr = 6'd0;
    B_Req  = 1'b0;
    #2;
    checkOutput("midB63_addrHeld", Mem_Addr, 63);
    tick; tick;
    checkOutput("midB63_ack", {A_Ack, B_Ack}, 2'b01);
    tick;
    checkOutput("midB63_idle", Busy, 0);

    // Reset lands in the ACCESS cycle of an A write
    A_Req = 1'b1; A_Write = 1'b1; A_Addr = 6'd9; A_WData = 32'h12345678;
    tick;
    Rst_n = 1'b0;
    A_Req = 1'b0;
    #1;
    checkOutput("rstWr_memWrite", Mem_Write, 0);
    checkOutput("rstWr_busyAccess", Busy, 1);
    tick;
    checkOutput("rstWr_aborted", {Busy, A_Ack, B_Ack}, 0);
    Rst_n = 1'b1;
    tick; tick;
    checkOutput("rstWr_noAck", {A_Ack, B_Ack}, 0);
    runSingle(1'b0, 1'b0, 6'd9, '0, "rdA9");

    // Boundary addresses without aliasing
    writeSnap = writeCount;
    runSingle(1'b0, 1'b1, 6'd0, 32'h00000001, "wrA0");
    runSingle(1'b1, 1'b1, 6'd63, 32'hFFFFFFFF, "wrB63");
    checkOutput("boundaryTwoPulses", writeCount - writeSnap, 2);
    runSingle(1'b0, 1'b0, 6'd0, '0, "rdA0");
    runSingle(1'b1, 1'b0, 6'd63, '0, "rdB63");
    checkOutput("rdA0_stable", A_RData, 32'h00000001);

    checkOutput("sbDrained", sbQueue.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
